hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Architectural HI/LO register pair for the MIPS datapath. It is the consumer end of the ALU's Hi/ALUResult outputs and the producer of the ALU's Hi_in/Lo_in operands.
- Accepts HI/LO writes from the writeback stage: mult, multu, madd, msub, mthi, mtlo.
- Contains a 32-cycle iterative divider for div/divu, which commits its result into HI/LO and drives a busy signal that the hazard unit uses to stall mfhi/mflo.

Parameters:
- BYPASS, 1, 1 = HiOut/LoOut forward same-cycle write data; 0 = registered values only.
- DIV_CYCLES, 32, iteration count of the divider; fixed at data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- WriteHi  in  1  write HI this edge.
- WriteLo  in  1  write LO this edge.
- HiWriteData  in  32  HI write data (ALU Hi output).
- LoWriteData  in  32  LO write data (ALU ALUResult).
- DivStart  in  1  start a division; sampled only in IDLE.
- DivSigned  in  1  1 = div (signed), 0 = divu; sampled with DivStart.
- DivA  in  32  dividend; sampled with DivStart.
- DivB  in  32  divisor; sampled with DivStart.
- HiOut  out  32  to ALU Hi_in.
- LoOut  out  32  to ALU Lo_in.
- DivBusy  out  1  divider in RUN or FIX.
- DivDone  out  1  one-cycle pulse after commit.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: HI=0, LO=0, state=IDLE, counter=0, DivBusy=0, DivDone=0. Reset aborts any division in flight; no commit and no DivDone follow.
- Direct writes:
  - On a rising edge with WriteHi=1, HI<=HiWriteData. WriteLo/LO works the same way, independently.
  - Both may be asserted together.
- Read path:
  - BYPASS=1: HiOut = WriteHi ? HiWriteData : HI, combinational. LoOut is formed the same way from WriteLo/LO.
  - BYPASS=0: HiOut=HI, LoOut=LO.
- Divider FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: on DivStart=1, latch DivSigned and the sign bits of DivA and DivB. Latch the magnitudes |DivA| and |DivB| when signed, raw values when unsigned. Clear the 32-bit remainder, set counter=DIV_CYCLES-1, go to RUN.
  - RUN: one restoring step per cycle, shifting the next dividend MSB into the remainder. If remainder >= divisor, subtract and set the quotient bit to 1, otherwise set it to 0. The subtract uses a 33-bit compare so no overflow occurs. Counter decrements; at counter==0, go to FIX.
  - FIX: apply signs, then commit LO<=quotient and HI<=remainder on this edge. Go to DONE.
    - Quotient is negated if signed and the signs differ.
    - Remainder takes the sign of the dividend.
  - DONE: DivDone=1 for exactly this cycle. Return to IDLE. DivStart is also accepted here, with IDLE semantics.
- Latency:
  - DivStart is sampled at edge N.
  - HI/LO are updated at edge N+33.
  - DivDone is high in the cycle after edge N+33.
  - DivBusy is high in the cycles after edges N through N+32.
- Divide by zero (DivB=0): LO=0xFFFFFFFF, HI=DivA unmodified; sign fix is skipped. Latency is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Simultaneous events:
  - DivStart while DivBusy=1 is ignored.
  - WriteHi/WriteLo during RUN update the registers normally. The FIX commit then overwrites them.
  - A WriteHi/WriteLo on the FIX edge loses to the divider commit.
  - DivStart together with WriteLo in IDLE: the write takes effect and the division starts.

Decomposition:
- Shared package hilo_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3);
  - DATA_W=32;
  - the divide-by-zero quotient constant 32'hFFFFFFFF.
- One natural sub-module, div_core. It contains the operand latch, the 32-step restoring datapath, the sign fix and the FSM, and outputs quotient, remainder, busy, done and a commit strobe.
- hilo_unit keeps the HI/LO registers, write/commit priority and the bypass muxes.

Test Plan:
- Reset, with Reset held 2 cycles after arbitrary writes -> HiOut=LoOut=0, DivBusy=0, DivDone=0.
- WriteHi=1 with 0x12345678 and WriteLo=1 with 0x9ABCDEF0 in the same cycle -> with BYPASS=1, same-cycle HiOut/LoOut show these values, and they are held after the edge once the write enables drop.
- divu: DivA=100, DivB=7 -> DivBusy high for 33 cycles, then LO=14, HI=2, DivDone a single-cycle pulse.
- div signed: DivA=0xFFFFFFF9 (-7), DivB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DivA=0x80000000, DivB=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DivA=5, DivB=0 -> LO=0xFFFFFFFF, HI=5, same latency.
- Reset mid-division: Reset at RUN cycle 10 -> DivBusy=0 next cycle, HI=LO=0, no DivDone. Separately, DivStart pulsed during RUN -> ignored, and the first result (e.g. 100/7) commits unaltered.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register pair and its iterative divider.
package hilo_pkg;

    localparam int DATA_W = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DATA_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/hilo_unit_div_core.sv
// Iterative restoring divider: operand latch, one quotient bit per RUN cycle,
// sign fix-up in FIX and a commit strobe for the HI/LO registers.
module hilo_unit_div_core
    import hilo_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              busy,
    output logic              done,
    output logic              commit
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    div_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] dvd_reg, dvd_next;    // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0] dvs_reg, dvs_next;
    logic [DATA_W-1:0] rem_reg, rem_next;
    logic [DATA_W-1:0] raw_a_reg, raw_a_next;
    logic              signed_reg, signed_next;
    logic              sign_a_reg, sign_a_next;
    logic              sign_b_reg, sign_b_next;

    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   diff;
    logic              fits;

    // 33-bit compare keeps the top remainder bit from overflowing.
    assign partial = {rem_reg, dvd_reg[DATA_W-1]};
    assign diff    = partial - {1'b0, dvs_reg};
    assign fits    = (partial >= {1'b0, dvs_reg});

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        rem_next    = rem_reg;
        raw_a_next  = raw_a_reg;
        signed_next = signed_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (state_reg == ST_DONE) begin
                    state_next = ST_IDLE;
                end
                if (start) begin
                    signed_next = signed_op;
                    sign_a_next = a[DATA_W-1];
                    sign_b_next = b[DATA_W-1];
                    raw_a_next  = a;
                    dvd_next    = (signed_op && a[DATA_W-1]) ? (~a + 1'b1) : a;
                    dvs_next    = (signed_op && b[DATA_W-1]) ? (~b + 1'b1) : b;
                    rem_next    = '0;
                    cnt_next    = CNT_W'(DIV_CYCLES - 1);
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                rem_next = fits ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
                dvd_next = {dvd_reg[DATA_W-2:0], fits};
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    cnt_next   = '0;
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            raw_a_reg  <= '0;
            signed_reg <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            rem_reg    <= rem_next;
            raw_a_reg  <= raw_a_next;
            signed_reg <= signed_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
        end
    end

    // Divide-by-zero bypasses the sign fix: all-ones quotient, raw dividend.
    always_comb begin
        if (dvs_reg == '0) begin
            quotient  = DIV_ZERO_QUO;
            remainder = raw_a_reg;
        end else begin
            quotient  = (signed_reg && (sign_a_reg ^ sign_b_reg)) ? (~dvd_reg + 1'b1) : dvd_reg;
            remainder = (signed_reg && sign_a_reg) ? (~rem_reg + 1'b1) : rem_reg;
        end
    end

    assign busy   = (state_reg == ST_RUN) || (state_reg == ST_FIX);
    assign commit = (state_reg == ST_FIX);
    assign done   = (state_reg == ST_DONE);

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair with direct writeback writes, divider
// commit (which wins over writes) and optional same-cycle read bypass.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter bit BYPASS     = 1'b1,
    parameter int DIV_CYCLES = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteHi,
    input  logic              WriteLo,
    input  logic [DATA_W-1:0] HiWriteData,
    input  logic [DATA_W-1:0] LoWriteData,
    input  logic              DivStart,
    input  logic              DivSigned,
    input  logic [DATA_W-1:0] DivA,
    input  logic [DATA_W-1:0] DivB,
    output logic [DATA_W-1:0] HiOut,
    output logic [DATA_W-1:0] LoOut,
    output logic              DivBusy,
    output logic              DivDone
);

    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic              div_commit;

    hilo_unit_div_core #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_core (
        .clk       (Clk),
        .srst      (Reset),
        .start     (DivStart),
        .signed_op (DivSigned),
        .a         (DivA),
        .b         (DivB),
        .quotient  (div_quo),
        .remainder (div_rem),
        .busy      (DivBusy),
        .done      (DivDone),
        .commit    (div_commit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (div_commit) begin
            hi_reg <= div_rem;
            lo_reg <= div_quo;
        end else begin
            if (WriteHi) begin
                hi_reg <= HiWriteData;
            end
            if (WriteLo) begin
                lo_reg <= LoWriteData;
            end
        end
    end

    generate
        if (BYPASS) begin : g_bypass
            assign HiOut = WriteHi ? HiWriteData : hi_reg;
            assign LoOut = WriteLo ? LoWriteData : lo_reg;
        end else begin : g_registered
            assign HiOut = hi_reg;
            assign LoOut = lo_reg;
        end
    endgenerate

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized self-checking bench for hilo_unit against a arithmetic reference model.
module tb_hilo_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        WriteHi = 1'b0;
    logic        WriteLo = 1'b0;
    logic [31:0] HiWriteData = '0;
    logic [31:0] LoWriteData = '0;
    logic        DivStart = 1'b0;
    logic        DivSigned = 1'b0;
    logic [31:0] DivA = '0;
    logic [31:0] DivB = '0;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        DivBusy;
    logic        DivDone;

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    hilo_unit #(.BYPASS(1'b1), .DIV_CYCLES(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .WriteHi     (WriteHi),
        .WriteLo     (WriteLo),
        .HiWriteData (HiWriteData),
        .LoWriteData (LoWriteData),
        .DivStart    (DivStart),
        .DivSigned   (DivSigned),
        .DivA        (DivA),
        .DivB        (DivB),
        .HiOut       (HiOut),
        .LoOut       (LoOut),
        .DivBusy     (DivBusy),
        .DivDone     (DivDone)
    );

    always #5 Clk = ~Clk;

    // Reference: MIPS div/divu with truncating quotient, remainder signed like dividend.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0];
            r = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Launches a division, optionally injecting a stray DivStart and HI/LO writes mid-run,
    // then checks busy length, done pulse and committed HI/LO.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit disturb);
        logic [31:0] q, r;
        int busy_cycles;
        int early_done;
        ref_div(sgn, a, b, q, r);
        @(negedge Clk);
        DivStart = 1'b1; DivSigned = sgn; DivA = a; DivB = b;
        @(posedge Clk); #1;
        DivStart = 1'b0;
        busy_cycles = 0;
        early_done = 0;
        while (DivBusy === 1'b1 && busy_cycles < 60) begin
            busy_cycles++;
            if (DivDone !== 1'b0) early_done++;
            if (disturb && busy_cycles == 5) begin
                DivStart = 1'b1; DivSigned = ~sgn; DivA = $urandom; DivB = $urandom_range(1, 9);
                WriteHi = 1'b1; WriteLo = 1'b1;
                HiWriteData = $urandom; LoWriteData = $urandom;
            end
            @(posedge Clk); #1;
            DivStart = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        end
        checks++;
        if (busy_cycles != 33) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=33", name, busy_cycles);
        end
        checks++;
        if (early_done != 0 || DivDone !== 1'b1) begin
            failures++;
            $display("FAIL %s done_pulse early=%0d done_at_end=%b exp early=0 done=1", name, early_done, DivDone);
        end
        checks++;
        if (LoOut !== q || HiOut !== r) begin
            failures++;
            $display("FAIL %s result a=%h b=%h s=%b got hi=%h lo=%h exp hi=%h lo=%h",
                     name, a, b, sgn, HiOut, LoOut, r, q);
        end
        hi_m = r;
        lo_m = q;
        @(posedge Clk); #1;
        checks++;
        if (DivDone !== 1'b0 || DivBusy !== 1'b0) begin
            failures++;
            $display("FAIL %s done_after got done=%b busy=%b exp 0 0", name, DivDone, DivBusy);
        end
        $display("div %s a=%h b=%h signed=%b hi=%h lo=%h busy=%0d", name, a, b, sgn, HiOut, LoOut, busy_cycles);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b0;
        WriteHi = 1'b1; WriteLo = 1'b1; HiWriteData = $urandom; LoWriteData = $urandom;
        @(negedge Clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        hi_m = '0; lo_m = '0;
        checks++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0 || DivBusy !== 1'b0 || DivDone !== 1'b0) begin
            failures++;
            $display("FAIL reset got hi=%h lo=%h busy=%b done=%b exp all 0", HiOut, LoOut, DivBusy, DivDone);
        end
        $display("reset hi=%h lo=%h busy=%b done=%b", HiOut, LoOut, DivBusy, DivDone);
    endtask

    task automatic test_direct_write();
        @(negedge Clk);
        WriteHi = 1'b1; WriteLo = 1'b1; HiWriteData = 32'h1234_5678; LoWriteData = 32'h9ABC_DEF0;
        #1;
        checks++;
        if (HiOut !== 32'h1234_5678 || LoOut !== 32'h9ABC_DEF0) begin
            failures++;
            $display("FAIL bypass got hi=%h lo=%h exp hi=12345678 lo=9abcdef0", HiOut, LoOut);
        end
        @(posedge Clk); #1;
        WriteHi = 1'b0; WriteLo = 1'b0; HiWriteData = '0; LoWriteData = '0;
        #1;
        checks++;
        if (HiOut !== 32'h1234_5678 || LoOut !== 32'h9ABC_DEF0) begin
            failures++;
            $display("FAIL held got hi=%h lo=%h exp hi=12345678 lo=9abcdef0", HiOut, LoOut);
        end
        hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;
        $display("write hi=%h lo=%h", HiOut, LoOut);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_hi, exp_lo;
            @(negedge Clk);
            WriteHi = 1'($urandom); WriteLo = 1'($urandom);
            HiWriteData = $urandom; LoWriteData = $urandom;
            #1;
            exp_hi = WriteHi ? HiWriteData : hi_m;
            exp_lo = WriteLo ? LoWriteData : lo_m;
            checks++;
            if (HiOut !== exp_hi || LoOut !== exp_lo) begin
                failures++;
                $display("FAIL rand_write[%0d] got hi=%h lo=%h exp hi=%h lo=%h", i, HiOut, LoOut, exp_hi, exp_lo);
            end
            $display("rand_write[%0d] wh=%b wl=%b hi=%h lo=%h", i, WriteHi, WriteLo, HiOut, LoOut);
            @(posedge Clk);
            hi_m = exp_hi; lo_m = exp_lo;
        end
        @(negedge Clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
    endtask

    task automatic test_divide();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("div_zero", 1'b0, 32'd5, 32'd0, 1'b0);
        run_div("div_zero_s", 1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_mid_div();
        int done_seen = 0;
        @(negedge Clk);
        DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd100; DivB = 32'd7;
        @(posedge Clk); #1;
        DivStart = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        hi_m = '0; lo_m = '0;
        checks++;
        if (DivBusy !== 1'b0 || HiOut !== 32'h0 || LoOut !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0 0 0", DivBusy, HiOut, LoOut);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (DivDone !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0 || HiOut !== 32'h0 || LoOut !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_after got done_count=%0d hi=%h lo=%h exp 0 0 0", done_seen, HiOut, LoOut);
        end
        $display("reset_mid busy=%b hi=%h lo=%h done_count=%0d", DivBusy, HiOut, LoOut, done_seen);
    endtask

    task automatic test_back_to_back();
        run_div("start_in_run", 1'b0, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            logic s;
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            s = 1'($urandom);
            run_div($sformatf("rand%0d", i), s, a, b, (i % 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_direct_write();
        test_divide();
        test_reset_mid_div();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
